// File: rtl/naive_bus_sram_slave.sv
// -----------------------------------------------------------------------------
// naive_bus_sram_slave
//
// Purpose:
//   Responder end of the naive_bus. Services single-beat 32-bit reads and
//   byte-enabled writes into an internal word-addressed RAM. A programmable
//   number of wait states is inserted before every grant. A read and a write
//   requested in the same idle cycle are arbitrated by WR_PRIORITY. Accesses
//   outside the address window are still granted, but they raise err_o and
//   do not touch the RAM.
//
// Parameters:
//   ADDR_BITS   - RAM depth is 2**ADDR_BITS words of 32 bits (at most 29)
//   BASE_ADDR   - window base, aligned to 2**(ADDR_BITS+2) bytes
//   WAIT_CYCLES - wait states before a grant, 0..15
//   WR_PRIORITY - 1: write wins a simultaneous request, 0: read wins
//
// Ports:
//   clk_i      in   1  clock, all state changes on the rising edge
//   rst_i      in   1  synchronous active-high reset
//   rd_req_i   in   1  read request, held by the master until rd_gnt_o
//   rd_addr_i  in  32  read byte address
//   rd_gnt_o   out  1  one-cycle read grant
//   rd_data_o  out 32  read data, valid the cycle after rd_gnt_o
//   wr_req_i   in   1  write request, held by the master until wr_gnt_o
//   wr_addr_i  in  32  write byte address
//   wr_data_i  in  32  write data
//   wr_be_i    in   4  byte enables, bit i enables wr_data_i[8i+7:8i]
//   wr_gnt_o   out  1  one-cycle write grant, write commits on the same edge
//   err_o      out  1  pulses with a grant whose address is out of window
// -----------------------------------------------------------------------------
module naive_bus_sram_slave #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          WR_PRIORITY = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  output logic        rd_gnt_o,
  output logic [31:0] rd_data_o,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_be_i,
  output logic        wr_gnt_o,
  output logic        err_o
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam int unsigned TAG_LSB   = ADDR_BITS + 2;
  localparam logic [3:0]  WAIT_LIM  = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_RD = 2'd1;
  localparam logic [1:0] WAIT_WR = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Address decode. The byte offset is dropped, so every access is treated
  // as word-aligned.
  // ---------------------------------------------------------------------------
  logic                 rd_in_win;
  logic                 wr_in_win;
  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wr_idx;
  logic                 unused_addr_lsbs;

  assign rd_in_win = (rd_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign wr_in_win = (wr_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign rd_idx    = rd_addr_i[ADDR_BITS+1:2];
  assign wr_idx    = wr_addr_i[ADDR_BITS+1:2];
  assign unused_addr_lsbs = ^{rd_addr_i[1:0], wr_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Arbitration between simultaneous requests seen in IDLE. The losing request
  // stays pending on the bus. It is picked up once the FSM is back in IDLE,
  // which is the cycle after the winner's grant.
  // ---------------------------------------------------------------------------
  logic sel_rd;
  logic sel_wr;

  assign sel_wr = wr_req_i & (~rd_req_i | WR_PRIORITY);
  assign sel_rd = rd_req_i & (~wr_req_i | ~WR_PRIORITY);

  // ---------------------------------------------------------------------------
  // Grant generation. With zero wait states the grant is combinational from
  // IDLE. Otherwise it fires when the hold counter reaches the limit while the
  // request is still asserted. Grants are held low for the whole time reset is
  // high, so a transaction that is interrupted by reset never completes.
  // ---------------------------------------------------------------------------
  logic rd_gnt;
  logic wr_gnt;

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (ZERO_WAIT) begin
          rd_gnt = sel_rd;
          wr_gnt = sel_wr;
        end
      end
      WAIT_RD: rd_gnt = rd_req_i & (cnt_q == WAIT_LIM);
      WAIT_WR: wr_gnt = wr_req_i & (cnt_q == WAIT_LIM);
      default: ;
    endcase
    if (rst_i) begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
    end
  end

  assign rd_gnt_o = rd_gnt;
  assign wr_gnt_o = wr_gnt;
  assign err_o    = (rd_gnt & ~rd_in_win) | (wr_gnt & ~wr_in_win);

  // ---------------------------------------------------------------------------
  // FSM and wait counter. The selection cycle counts as cnt == 0, so the FSM
  // enters a WAIT state with cnt = 1. A grant, or a request dropped early,
  // returns the FSM to IDLE. A new selection can therefore be made in the
  // cycle right after a grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (!ZERO_WAIT) begin
          if (sel_wr) begin
            state_d = WAIT_WR;
            cnt_d   = 4'd1;
          end else if (sel_rd) begin
            state_d = WAIT_RD;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT_RD: begin
        if (!rd_req_i || rd_gnt) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_WR: begin
        if (!wr_req_i || wr_gnt) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. There is one byte-wide RAM per lane, so the byte enables map
  // directly onto independent write strobes. RAM contents are not affected by
  // reset. Each lane's read register loads on the read-grant edge and keeps its
  // value until the next read grant. An out-of-window read loads zero. Only one
  // grant can be active in a cycle, so a lane never reads and writes in the
  // same cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk_i) begin
      if (wr_gnt && wr_in_win && wr_be_i[gi]) begin
        mem_q[wr_idx] <= wr_data_i[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_byte_q <= 8'h00;
      end else if (rd_gnt) begin
        rd_byte_q <= rd_in_win ? mem_q[rd_idx] : 8'h00;
      end
    end

    assign rd_data_o[gi*8 +: 8] = rd_byte_q;
  end

endmodule
